// File: rtl/exponent_seq.sv
// Sequential index-to-one-hot converter: a single '1' walks left one bit per
// clock until it reaches position inNumber, with valid/ready on both sides.
module exponent_seq #(
   parameter int unsigned BIN_SIZE  = 8,
   parameter int unsigned BOUT_SIZE = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inValid,
   output logic                 inReady,
   input  logic [BOUT_SIZE-1:0] inNumber,
   output logic                 outValid,
   input  logic                 outReady,
   output logic [BIN_SIZE-1:0]  outVector,
   output logic                 outErr,
   output logic                 busy
);

   // One extra bit so BIN_SIZE itself is representable for the range check.
   localparam int unsigned CW = BOUT_SIZE + 1;
   localparam logic [CW-1:0] BIN_LIM = CW'(BIN_SIZE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [BOUT_SIZE-1:0]  count_q, count_d;
   logic [BIN_SIZE-1:0]   vec_q, vec_d;
   logic                  err_q, err_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic                  busy_q, busy_d;
   logic                  in_range;

   assign in_range = ({1'b0, inNumber} < BIN_LIM);

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         vec_q       <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         vec_q       <= vec_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      vec_d       = vec_q;
      err_d       = err_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      unique case (state_q)
         IDLE: begin
            if (inValid && in_ready_q) begin
               in_ready_d = 1'b0;
               if (in_range) begin
                  vec_d   = BIN_SIZE'(1);
                  count_d = inNumber;
                  busy_d  = 1'b1;
                  state_d = SHIFT;
               end else begin
                  // Out-of-range index reports straight away with an empty vector.
                  vec_d       = '0;
                  err_d       = 1'b1;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         SHIFT: begin
            if (count_q == '0) begin
               busy_d      = 1'b0;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               vec_d   = vec_q << 1;
               count_d = count_q - BOUT_SIZE'(1);
            end
         end
         DONE: begin
            if (out_valid_q && outReady) begin
               err_d       = 1'b0;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign inReady   = in_ready_q;
   assign outValid  = out_valid_q;
   assign outVector = vec_q;
   assign outErr    = err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_exponent_seq.sv
// Directed bench for exponent_seq: an 8-bit instance for the main sweep, stall
// and async reset, and a 6-bit instance for the out-of-range path.
module tb_exponent_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       a_inValid, a_inReady, a_outValid, a_outReady, a_outErr, a_busy;
   logic [2:0] a_inNumber;
   logic [7:0] a_outVector;

   logic       b_inValid, b_inReady, b_outValid, b_outReady, b_outErr, b_busy;
   logic [2:0] b_inNumber;
   logic [5:0] b_outVector;

   int total = 0;
   int bad   = 0;

   exponent_seq #(.BIN_SIZE(8), .BOUT_SIZE(3)) u_dut8 (
      .clk(clk), .rst(rst),
      .inValid(a_inValid), .inReady(a_inReady), .inNumber(a_inNumber),
      .outValid(a_outValid), .outReady(a_outReady),
      .outVector(a_outVector), .outErr(a_outErr), .busy(a_busy)
   );

   exponent_seq #(.BIN_SIZE(6), .BOUT_SIZE(3)) u_dut6 (
      .clk(clk), .rst(rst),
      .inValid(b_inValid), .inReady(b_inReady), .inNumber(b_inNumber),
      .outValid(b_outValid), .outReady(b_outReady),
      .outVector(b_outVector), .outErr(b_outErr), .busy(b_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Stand-in for the logarithm block: index of the highest set bit.
   function automatic logic [31:0] log2_enc(input logic [7:0] v);
      for (int i = 7; i >= 0; i--)
         if (v[i]) return 32'(i);
      return 32'hFFFF_FFFF;
   endfunction

   // One conversion on the 8-bit instance; stall>0 holds outReady low 4 cycles.
   task automatic a_convert(input logic [2:0] n, input int stall);
      int         lat;
      logic       rdy_seen, busy_low;
      logic [7:0] exp_vec;
      exp_vec = 8'd1 << n;
      @(negedge clk);
      a_inNumber = n;
      a_inValid  = 1'b1;
      a_outReady = (stall == 0);
      @(posedge clk); #1;
      a_inValid = 1'b0;
      lat = 0; rdy_seen = 1'b0; busy_low = 1'b0;
      while (!a_outValid && lat < 20) begin
         if (a_inReady) rdy_seen = 1'b1;
         if (!a_busy) busy_low = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("lat_n%0d", n), 32'(lat), 32'(n) + 32'd1);
      check($sformatf("rdy_low_n%0d", n), {31'd0, rdy_seen}, 32'd0);
      check($sformatf("busy_n%0d", n), {31'd0, busy_low}, 32'd0);
      check($sformatf("vec_n%0d", n), {24'd0, a_outVector}, {24'd0, exp_vec});
      check($sformatf("err_n%0d", n), {31'd0, a_outErr}, 32'd0);
      check($sformatf("loop_n%0d", n), log2_enc(a_outVector), 32'(n));
      if (stall > 0) begin
         repeat (4) begin
            check("stall_vec", {24'd0, a_outVector}, {24'd0, exp_vec});
            check("stall_valid", {31'd0, a_outValid}, 32'd1);
            check("stall_rdy", {31'd0, a_inReady}, 32'd0);
            @(posedge clk); #1;
         end
         check("stall_vec_end", {24'd0, a_outVector}, {24'd0, exp_vec});
         a_outReady = 1'b1;
      end
      @(posedge clk); #1;
      check($sformatf("idle_valid_n%0d", n), {31'd0, a_outValid}, 32'd0);
      check($sformatf("idle_rdy_n%0d", n), {31'd0, a_inReady}, 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      a_inValid = 1'b0; a_inNumber = '0; a_outReady = 1'b0;
      b_inValid = 1'b0; b_inNumber = '0; b_outReady = 1'b0;
      #12;
      check("rst_rdy", {31'd0, a_inReady}, 32'd1);
      check("rst_valid", {31'd0, a_outValid}, 32'd0);
      check("rst_vec", {24'd0, a_outVector}, 32'd0);
      check("rst_err", {31'd0, a_outErr}, 32'd0);
      check("rst_busy", {31'd0, a_busy}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // Sweep all indices with the consumer always ready.
      for (int n = 0; n < 8; n++) a_convert(3'(n), 0);

      // Consumer back-pressure holds the result.
      a_convert(3'd5, 1);

      // Out-of-range index on the 6-bit instance: DONE is entered on the accept edge.
      @(negedge clk);
      b_inNumber = 3'd6; b_inValid = 1'b1; b_outReady = 1'b1;
      @(posedge clk); #1;
      b_inValid = 1'b0;
      check("err_valid", {31'd0, b_outValid}, 32'd1);
      check("err_flag", {31'd0, b_outErr}, 32'd1);
      check("err_vec", {26'd0, b_outVector}, 32'd0);
      check("err_rdy", {31'd0, b_inReady}, 32'd0);
      @(posedge clk); #1;
      check("err_idle_valid", {31'd0, b_outValid}, 32'd0);
      check("err_idle_flag", {31'd0, b_outErr}, 32'd0);
      check("err_idle_rdy", {31'd0, b_inReady}, 32'd1);

      // Top in-range index on the 6-bit instance.
      begin
         int lat;
         @(negedge clk);
         b_inNumber = 3'd5; b_inValid = 1'b1;
         @(posedge clk); #1;
         b_inValid = 1'b0;
         lat = 0;
         while (!b_outValid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
         end
         check("b5_lat", 32'(lat), 32'd6);
         check("b5_vec", {26'd0, b_outVector}, 32'h20);
         check("b5_err", {31'd0, b_outErr}, 32'd0);
         @(posedge clk); #1;
         check("b5_idle_rdy", {31'd0, b_inReady}, 32'd1);
      end

      // Asynchronous reset in the middle of a long conversion.
      @(negedge clk);
      a_inNumber = 3'd7; a_inValid = 1'b1; a_outReady = 1'b1;
      @(posedge clk); #1;
      a_inValid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_rdy", {31'd0, a_inReady}, 32'd1);
      check("arst_valid", {31'd0, a_outValid}, 32'd0);
      check("arst_vec", {24'd0, a_outVector}, 32'd0);
      check("arst_err", {31'd0, a_outErr}, 32'd0);
      check("arst_busy", {31'd0, a_busy}, 32'd0);
      @(negedge clk); rst = 1'b0;
      a_convert(3'd2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
